// File: rtl/rr_priority_pick.sv
// Wrap-around priority search for the round-robin arbiter.
// Finds the first set request bit at or after ptr, wrapping past n-1 back to 0.
// Purely combinational. When no bit is set, found is low and idx echoes ptr.
module rr_priority_pick #(
  parameter int n = 4
) (
  input  logic [n-1:0]         req,
  input  logic [$clog2(n)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(n)-1:0] idx
);

  localparam int IW = $clog2(n);
  localparam logic [IW:0] N_C = (IW+1)'(n);

  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;

  // Scan offsets from the far end back to ptr so the nearest requester is written last and wins
  always_comb begin
    found  = 1'b0;
    idx    = ptr;
    sum_s  = {(IW+1){1'b0}};
    cand_s = {IW{1'b0}};
    for (int i = n - 1; i >= 0; i--) begin
      sum_s  = {1'b0, ptr} + (IW+1)'(i);
      cand_s = (sum_s >= N_C) ? IW'(sum_s - N_C) : IW'(sum_s);
      found  = found | req[cand_s];
      idx    = req[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a bounded grant hold time.
// A grant is issued one clock after requests are seen in IDLE, held until the
// grantee finishes, drops its request or hits max_hold cycles, and is always
// followed by exactly one idle bubble in which the next winner is chosen.
// The search starts from the requester after the most recent grantee.
module round_robin_arbiter #(
  parameter int n        = 4,
  parameter int max_hold = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [n-1:0]         req,
  input  logic                 done,
  output logic [n-1:0]         gnt,
  output logic [$clog2(n)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  localparam int IW = $clog2(n);
  localparam int CW = $clog2(max_hold + 1);

  localparam logic [CW-1:0] MAX_HOLD_C    = CW'(max_hold);
  localparam logic [IW-1:0] LAST_IDX_C    = IW'(n - 1);
  localparam logic [n-1:0]  ONE_HOT_LSB_C = {{(n-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e        state_q,     state_d;
  logic [IW-1:0] ptr_q,       ptr_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [n-1:0]  gnt_q,       gnt_d;
  logic [IW-1:0] gnt_idx_q,   gnt_idx_d;
  logic          gnt_valid_q, gnt_valid_d;

  logic          pick_found_s;
  logic [IW-1:0] pick_idx_s;
  logic          release_s;

  rr_priority_pick #(
    .n(n)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Next-state logic: arbitrate in IDLE, hold or release in GRANT
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    release_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // done is meaningless without a grant, so only req matters here
        if (pick_found_s) begin
          state_d     = ST_GRANT;
          gnt_d       = ONE_HOT_LSB_C << pick_idx_s;
          gnt_idx_d   = pick_idx_s;
          gnt_valid_d = 1'b1;
          cnt_d       = CW'(1);
        end else begin
          state_d     = ST_IDLE;
          gnt_d       = {n{1'b0}};
          gnt_valid_d = 1'b0;
          cnt_d       = {CW{1'b0}};
        end
      end

      ST_GRANT: begin
        // Any release condition, alone or combined, produces a single release
        release_s = done | ~req[gnt_idx_q] | (cnt_q == MAX_HOLD_C);
        if (release_s) begin
          state_d     = ST_IDLE;
          gnt_d       = {n{1'b0}};
          gnt_valid_d = 1'b0;
          cnt_d       = {CW{1'b0}};
          ptr_d       = (gnt_idx_q == LAST_IDX_C) ? {IW{1'b0}} : gnt_idx_q + IW'(1);
        end else begin
          state_d = ST_GRANT;
          cnt_d   = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        gnt_d       = {n{1'b0}};
        gnt_valid_d = 1'b0;
        cnt_d       = {CW{1'b0}};
      end
    endcase
  end

  // State, pointer, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {IW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      gnt_q       <= {n{1'b0}};
      gnt_idx_q   <= {IW{1'b0}};
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed testbench for round_robin_arbiter with n = 4, max_hold = 8.
module tb_round_robin_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_valid;
  logic [6:0]   obs;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  round_robin_arbiter #(
    .n        (N),
    .max_hold (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign obs = {gnt_valid, gnt_idx, gnt};

  // Expected {gnt_valid, gnt_idx, gnt} from hand-chosen valid flag and index
  function automatic logic [6:0] exp_out(input logic v, input logic [1:0] idx);
    logic [3:0] oh;
    oh = v ? (4'b0001 << idx) : 4'b0000;
    return {v, idx, oh};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 4'b0000; done = 1'b0;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b0, 2'd0)) begin
      tests_failed++;
      $display("FAIL reset_edge: got %b expected %b", obs, exp_out(1'b0, 2'd0));
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (obs !== exp_out(1'b0, 2'd0)) begin
        tests_failed++;
        $display("FAIL reset_idle_%0d: got %b expected %b", c, obs, exp_out(1'b0, 2'd0));
      end
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (obs !== exp_out(1'b1, order[k])) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: got %b expected %b", k, obs, exp_out(1'b1, order[k]));
      end
      done = 1'b1;
      tick();
      tests_run++;
      if (obs !== exp_out(1'b0, order[k])) begin
        tests_failed++;
        $display("FAIL rr_bubble_%0d: got %b expected %b", k, obs, exp_out(1'b0, order[k]));
      end
      done = 1'b0;
    end
    req = 4'b0000;
  endtask

  // Pointer is 1 on entry: grant 2, then 3 wins over 0, then wrap to 0
  task automatic test_wrap;
    req = 4'b0100;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b1, 2'd2)) begin
      tests_failed++;
      $display("FAIL wrap_grant2: got %b expected %b", obs, exp_out(1'b1, 2'd2));
    end
    req = 4'b1001;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b0, 2'd2)) begin
      tests_failed++;
      $display("FAIL wrap_release2: got %b expected %b", obs, exp_out(1'b0, 2'd2));
    end
    tick();
    tests_run++;
    if (obs !== exp_out(1'b1, 2'd3)) begin
      tests_failed++;
      $display("FAIL wrap_grant3: got %b expected %b", obs, exp_out(1'b1, 2'd3));
    end
    done = 1'b1;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b0, 2'd3)) begin
      tests_failed++;
      $display("FAIL wrap_release3: got %b expected %b", obs, exp_out(1'b0, 2'd3));
    end
    done = 1'b0;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b1, 2'd0)) begin
      tests_failed++;
      $display("FAIL wrap_grant0: got %b expected %b", obs, exp_out(1'b1, 2'd0));
    end
    req = 4'b0000;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b0, 2'd0)) begin
      tests_failed++;
      $display("FAIL wrap_release0: got %b expected %b", obs, exp_out(1'b0, 2'd0));
    end
  endtask

  // Pointer is 1 on entry; grant 2 times out after 8 cycles, leaving ptr = 3
  task automatic test_timeout;
    req = 4'b0100;
    for (int c = 1; c <= MAX_HOLD; c++) begin
      tick();
      tests_run++;
      if (obs !== exp_out(1'b1, 2'd2)) begin
        tests_failed++;
        $display("FAIL timeout_hold_%0d: got %b expected %b", c, obs, exp_out(1'b1, 2'd2));
      end
      if (c == 4) req = 4'b0111;
      if (c == 6) req = 4'b0100;
    end
    tick();
    tests_run++;
    if (obs !== exp_out(1'b0, 2'd2)) begin
      tests_failed++;
      $display("FAIL timeout_release: got %b expected %b", obs, exp_out(1'b0, 2'd2));
    end
    tick();
    tests_run++;
    if (obs !== exp_out(1'b1, 2'd2)) begin
      tests_failed++;
      $display("FAIL timeout_regrant: got %b expected %b", obs, exp_out(1'b1, 2'd2));
    end
    req = 4'b0000;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b0, 2'd2)) begin
      tests_failed++;
      $display("FAIL timeout_exit: got %b expected %b", obs, exp_out(1'b0, 2'd2));
    end
  endtask

  // Pointer is 3 on entry; grant 1, drop req[1] in grant cycle 3, ptr becomes 2
  task automatic test_req_drop;
    req = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests_run++;
      if (obs !== exp_out(1'b1, 2'd1)) begin
        tests_failed++;
        $display("FAIL drop_hold_%0d: got %b expected %b", c, obs, exp_out(1'b1, 2'd1));
      end
    end
    req = 4'b0000;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b0, 2'd1)) begin
      tests_failed++;
      $display("FAIL drop_release: got %b expected %b", obs, exp_out(1'b0, 2'd1));
    end
    req = 4'b1111;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b1, 2'd2)) begin
      tests_failed++;
      $display("FAIL drop_next_ptr2: got %b expected %b", obs, exp_out(1'b1, 2'd2));
    end
  endtask

  // Grant to 2 is active on entry; reset clears it and returns ptr to 0
  task automatic test_reset_mid_grant;
    reset = 1'b1;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b0, 2'd0)) begin
      tests_failed++;
      $display("FAIL midreset_drop: got %b expected %b", obs, exp_out(1'b0, 2'd0));
    end
    reset = 1'b0;
    req = 4'b0101;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b1, 2'd0)) begin
      tests_failed++;
      $display("FAIL midreset_first: got %b expected %b", obs, exp_out(1'b1, 2'd0));
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b1, 2'd2)) begin
      tests_failed++;
      $display("FAIL midreset_second: got %b expected %b", obs, exp_out(1'b1, 2'd2));
    end
    done = 1'b1;
    req = 4'b0000;
    tick();
    done = 1'b0;
  endtask

  // Pointer is 3 on entry; done in IDLE is ignored, then done coincides with timeout
  task automatic test_simultaneous;
    done = 1'b1;
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if (obs !== exp_out(1'b0, 2'd2)) begin
        tests_failed++;
        $display("FAIL idle_done_%0d: got %b expected %b", c, obs, exp_out(1'b0, 2'd2));
      end
    end
    done = 1'b0;
    req = 4'b0100;
    for (int c = 1; c <= MAX_HOLD; c++) begin
      tick();
      tests_run++;
      if (obs !== exp_out(1'b1, 2'd2)) begin
        tests_failed++;
        $display("FAIL simul_hold_%0d: got %b expected %b", c, obs, exp_out(1'b1, 2'd2));
      end
      if (c == MAX_HOLD) done = 1'b1;
    end
    tick();
    done = 1'b0;
    tests_run++;
    if (obs !== exp_out(1'b0, 2'd2)) begin
      tests_failed++;
      $display("FAIL simul_release: got %b expected %b", obs, exp_out(1'b0, 2'd2));
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if (obs !== exp_out(1'b1, 2'd2)) begin
        tests_failed++;
        $display("FAIL simul_regrant_%0d: got %b expected %b", c, obs, exp_out(1'b1, 2'd2));
      end
    end
    req = 4'b0000;
    tick();
    tests_run++;
    if (obs !== exp_out(1'b0, 2'd2)) begin
      tests_failed++;
      $display("FAIL simul_exit: got %b expected %b", obs, exp_out(1'b0, 2'd2));
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_req_drop();
    test_reset_mid_grant();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
